// File: rtl/aes_pkg.sv
// Shared types, constants and the rcon table for AES-128 key expansion.
package aes_pkg;

   localparam int AES_NR = 10;
   localparam int AES_KW = 128;

   typedef logic [AES_KW-1:0] round_key_t;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      DONE
   } ks_state_t;

   // Round constant for expansion round idx+1; indices outside 0..9 return 0.
   function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd0:    r = 8'h01;
         4'd1:    r = 8'h02;
         4'd2:    r = 8'h04;
         4'd3:    r = 8'h08;
         4'd4:    r = 8'h10;
         4'd5:    r = 8'h20;
         4'd6:    r = 8'h40;
         4'd7:    r = 8'h80;
         4'd8:    r = 8'h1b;
         4'd9:    r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Key-load and round-key read bus of the key-schedule controller.
interface aes_key_sched_ctrl_if;
   import aes_pkg::*;

   logic       start;
   round_key_t key_in;
   logic       ready;
   logic       busy;
   logic       keys_valid;
   logic [3:0] rk_addr;
   round_key_t rk_rdata;

   modport master (
      output start, key_in, rk_addr,
      input  ready, busy, keys_valid, rk_rdata
   );

   modport slave (
      input  start, key_in, rk_addr,
      output ready, busy, keys_valid, rk_rdata
   );

endinterface

// File: rtl/aes_key_round.sv
// One combinational AES-128 key-expansion round: RotWord, SubWord, rcon XOR, word chain.
module aes_key_round
   import aes_pkg::*;
(
   input  round_key_t prev_key_i,
   input  logic [3:0] rc_i,
   output round_key_t next_key_o
);

   // Forward S-box, byte 0 in the most significant position.
   localparam logic [2047:0] SboxTable = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SboxTable[2047 - 8 * int'(b) -: 8];
   endfunction

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot, sub, temp;
   logic [31:0] n0, n1, n2, n3;

   // Single round: w3 is rotated, substituted and mixed with rcon(rc-1).
   always_comb begin
      w0   = prev_key_i[127:96];
      w1   = prev_key_i[95:64];
      w2   = prev_key_i[63:32];
      w3   = prev_key_i[31:0];
      rot  = {w3[23:0], w3[31:24]};
      sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
      temp = sub ^ {aes_rcon(rc_i - 4'd1), 24'h000000};
      n0   = w0 ^ temp;
      n1   = w1 ^ n0;
      n2   = w2 ^ n1;
      n3   = w3 ^ n2;
      next_key_o = {n0, n1, n2, n3};
   end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: loads a cipher key, runs rounds 1..10 one per
// clock through aes_key_round and holds all 11 round keys for combinational reads.
// Optional macro AES_KS_ZEROIZE_EN clears rk[1..10] on every accepted start.
module aes_key_sched_ctrl
   import aes_pkg::*;
(
   input logic                  CLK,
   input logic                  RST,
   aes_key_sched_ctrl_if.slave  bus
);

   ks_state_t  state_q, state_d;
   logic [3:0] rc_q, rc_d;
   round_key_t rk_q [AES_NR+1];
   round_key_t rk_d [AES_NR+1];
   round_key_t round_in, round_out;
   round_key_t rdata;

   aes_key_round u_round (
      .prev_key_i (round_in),
      .rc_i       (rc_q),
      .next_key_o (round_out)
   );

   // Select rk[rc-1] as the datapath source; zero outside the valid rc range.
   always_comb begin
      round_in = '0;
      for (int i = 1; i <= AES_NR; i++) begin
         if (rc_q == 4'(i)) round_in = rk_q[i-1];
      end
   end

   // Next-state, counter and key-bank update.
   always_comb begin
      state_d = state_q;
      rc_d    = rc_q;
      for (int i = 0; i <= AES_NR; i++) rk_d[i] = rk_q[i];
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               rk_d[0] = bus.key_in;
`ifdef AES_KS_ZEROIZE_EN
               for (int i = 1; i <= AES_NR; i++) rk_d[i] = '0;
`endif
               rc_d    = 4'd1;
               state_d = EXPAND;
            end
         end
         EXPAND: begin
            for (int i = 1; i <= AES_NR; i++) begin
               if (rc_q == 4'(i)) rk_d[i] = round_out;
            end
            // rc saturates at 10; leaving EXPAND is what ends the schedule.
            if (rc_q == 4'(AES_NR)) begin
               state_d = DONE;
            end else begin
               rc_d = rc_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter and key bank; async reset clears everything.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         rc_q    <= 4'd0;
         for (int i = 0; i <= AES_NR; i++) rk_q[i] <= '0;
      end else begin
         state_q <= state_d;
         rc_q    <= rc_d;
         for (int i = 0; i <= AES_NR; i++) rk_q[i] <= rk_d[i];
      end
   end

   // Read port: round keys are exposed only once the whole schedule is valid.
   always_comb begin
      rdata = '0;
      if (state_q == DONE) begin
         for (int i = 0; i <= AES_NR; i++) begin
            if (bus.rk_addr == 4'(i)) rdata = rk_q[i];
         end
      end
   end

   assign bus.ready      = (state_q == IDLE) || (state_q == DONE);
   assign bus.busy       = (state_q == EXPAND);
   assign bus.keys_valid = (state_q == DONE);
   assign bus.rk_rdata   = rdata;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl using FIPS-197 and all-zero key vectors.
module tb_aes_key_sched_ctrl;
   import aes_pkg::*;

   logic CLK;
   logic RST;
   int   total;
   int   bad;

   aes_key_sched_ctrl_if bus_if ();

   aes_key_sched_ctrl dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus_if)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0]   addr;
      logic [127:0] exp;
   } vec_t;

   vec_t fips_tab [16];

   localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Wait for keys_valid, returning the number of edges taken (bounded).
   task automatic wait_valid(output int n);
      n = 0;
      while (!bus_if.keys_valid && n < 30) begin
         tick();
         n++;
      end
   endtask

   task automatic check_fips_table();
      for (int i = 0; i < 16; i++) begin
         bus_if.rk_addr = fips_tab[i].addr;
         #1;
         chk($sformatf("fips_rk[%0d]", fips_tab[i].addr), bus_if.rk_rdata, fips_tab[i].exp);
      end
      bus_if.rk_addr = 4'd0;
   endtask

   initial begin
      int n;
      total = 0;
      bad   = 0;

      fips_tab[0]  = '{4'd0,  FipsKey};
      fips_tab[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
      fips_tab[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
      fips_tab[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
      fips_tab[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
      fips_tab[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
      fips_tab[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
      fips_tab[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
      fips_tab[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
      fips_tab[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
      fips_tab[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      for (int i = 11; i < 16; i++) fips_tab[i] = '{4'(i), 128'h0};

      bus_if.start   = 1'b0;
      bus_if.key_in  = '0;
      bus_if.rk_addr = 4'd0;
      RST = 1'b1;
      #12;
      RST = 1'b0;
      tick();

      // Reset state.
      chk("rst_ready", 128'(bus_if.ready), 128'd1);
      chk("rst_busy", 128'(bus_if.busy), 128'd0);
      chk("rst_valid", 128'(bus_if.keys_valid), 128'd0);
      chk("rst_rdata", bus_if.rk_rdata, 128'h0);

      // First schedule with a one-cycle start.
      bus_if.key_in = FipsKey;
      bus_if.start  = 1'b1;
      tick();
      bus_if.start  = 1'b0;
      chk("e0_busy", 128'(bus_if.busy), 128'd1);
      chk("e0_ready", 128'(bus_if.ready), 128'd0);
      chk("e0_rdata_hidden", bus_if.rk_rdata, 128'h0);
      wait_valid(n);
      chk("latency1", 128'(n), 128'd10);
      chk("done_busy", 128'(bus_if.busy), 128'd0);
      check_fips_table();

      // Restart from DONE with start pulses at EXPAND cycles 3 and 7.
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      chk("restart_valid_drop", 128'(bus_if.keys_valid), 128'd0);
      n = 0;
      while (!bus_if.keys_valid && n < 30) begin
         bus_if.start = (n == 2 || n == 6);
         tick();
         n++;
      end
      bus_if.start = 1'b0;
      chk("latency_ignored_start", 128'(n), 128'd10);
      check_fips_table();

      // Reset in the 5th EXPAND cycle.
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("mid_busy", 128'(bus_if.busy), 128'd1);
      RST = 1'b1;
      #1;
      chk("rst_mid_ready", 128'(bus_if.ready), 128'd1);
      chk("rst_mid_busy", 128'(bus_if.busy), 128'd0);
      chk("rst_mid_valid", 128'(bus_if.keys_valid), 128'd0);
      chk("rst_mid_bank", dut.rk_q[3], 128'h0);
      #2;
      RST = 1'b0;
      tick();
      chk("post_rst_valid", 128'(bus_if.keys_valid), 128'd0);
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      wait_valid(n);
      chk("latency_after_rst", 128'(n), 128'd10);
      check_fips_table();

      // Restart from DONE with the all-zero key.
      bus_if.key_in = '0;
      bus_if.start  = 1'b1;
      tick();
      bus_if.start  = 1'b0;
      chk("zero_valid_drop", 128'(bus_if.keys_valid), 128'd0);
`ifdef AES_KS_ZEROIZE_EN
      chk("zeroize_rk5", dut.rk_q[5], 128'h0);
`else
      chk("stale_rk5", dut.rk_q[5], 128'hd4d1c6f87c839d87caf2b8bc11f915bc);
`endif
      wait_valid(n);
      chk("latency_zero", 128'(n), 128'd10);
      bus_if.rk_addr = 4'd0;
      #1;
      chk("zero_rk0", bus_if.rk_rdata, 128'h0);
      bus_if.rk_addr = 4'd1;
      #1;
      chk("zero_rk1", bus_if.rk_rdata, 128'h62636363626363636263636362636363);
      bus_if.rk_addr = 4'd10;
      #1;
      chk("zero_rk10", bus_if.rk_rdata, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      bus_if.rk_addr = 4'd15;
      #1;
      chk("zero_rk15", bus_if.rk_rdata, 128'h0);

      // Back-to-back: start held high restarts on the edge after completion.
      bus_if.key_in = FipsKey;
      bus_if.start  = 1'b1;
      tick();
      wait_valid(n);
      chk("b2b_latency1", 128'(n), 128'd10);
      tick();
      bus_if.start = 1'b0;
      chk("b2b_restart_busy", 128'(bus_if.busy), 128'd1);
      chk("b2b_restart_valid", 128'(bus_if.keys_valid), 128'd0);
      wait_valid(n);
      chk("b2b_latency2", 128'(n), 128'd10);
      check_fips_table();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
